// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Arbitrates an instruction-fetch port and a load/store port onto a
//            single SRAM-style bus with split address/data handshakes.
//            At most one bus transaction is outstanding at any time.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_req/addr               fetch request, held until inst_data_ok
//   inst_rdata/data_ok          fetched word, one-cycle completion pulse
//   data_req/wen/addr/wdata     load/store request, held until data_data_ok
//   data_rdata/data_ok          load word, one-cycle completion pulse
//   mem_req/wr/wstrb/addr/wdata shared-bus request (registered, stable until
//                               mem_addr_ok)
//   mem_addr_ok/data_ok/rdata   shared-bus handshakes and response data
//   busy                        high whenever the arbiter is not idle
//
// Parameters:
//   RR_EN  1 = round-robin on simultaneous requests, 0 = data port wins
//
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic c_rr_en = (RR_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_D_ADDR = 3'd1,
        S_D_WAIT = 3'd2,
        S_I_ADDR = 3'd3,
        S_I_WAIT = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_last_data;   // 1 = data port completed most recently
    logic        r_mem_req;
    logic        r_mem_wr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_inst_ok;
    logic        r_data_ok;

    logic        w_inst_pend;
    logic        w_data_pend;
    logic        w_grant_data;
    logic        w_grant_inst;

    // A master still holds req during its own completion cycle; masking it
    // with the data_ok pulse keeps that same request from being re-granted.
    assign w_inst_pend  = inst_req & ~r_inst_ok;
    assign w_data_pend  = data_req & ~r_data_ok;

    // On a tie the data port wins unless round-robin is on and data was the
    // last port served.
    assign w_grant_data = w_data_pend & (~w_inst_pend | ~c_rr_en | ~r_last_data);
    assign w_grant_inst = w_inst_pend & ~w_grant_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_last_data  <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_wstrb  <= 4'h0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
            r_inst_ok    <= 1'b0;
            r_data_ok    <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            r_inst_ok <= 1'b0;
            r_data_ok <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_data) begin
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= |data_wen;
                        r_mem_wstrb <= data_wen;
                        r_mem_addr  <= data_addr;
                        r_mem_wdata <= data_wdata;
                        r_state     <= S_D_ADDR;
                    end else if (w_grant_inst) begin
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_wstrb <= 4'h0;
                        r_mem_addr  <= inst_addr;
                        r_mem_wdata <= 32'h0;
                        r_state     <= S_I_ADDR;
                    end
                end

                S_D_ADDR: begin
                    if (mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        // The response may arrive in the acceptance cycle.
                        if (mem_data_ok) begin
                            r_data_rdata <= mem_rdata;
                            r_data_ok    <= 1'b1;
                            r_last_data  <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_D_WAIT;
                        end
                    end
                end

                S_D_WAIT: begin
                    if (mem_data_ok) begin
                        r_data_rdata <= mem_rdata;
                        r_data_ok    <= 1'b1;
                        r_last_data  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end

                S_I_ADDR: begin
                    if (mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        if (mem_data_ok) begin
                            r_inst_rdata <= mem_rdata;
                            r_inst_ok    <= 1'b1;
                            r_last_data  <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_I_WAIT;
                        end
                    end
                end

                S_I_WAIT: begin
                    if (mem_data_ok) begin
                        r_inst_rdata <= mem_rdata;
                        r_inst_ok    <= 1'b1;
                        r_last_data  <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_rdata   = r_inst_rdata;
    assign inst_data_ok = r_inst_ok;
    assign data_rdata   = r_data_rdata;
    assign data_data_ok = r_data_ok;
    assign mem_req      = r_mem_req;
    assign mem_wr       = r_mem_wr;
    assign mem_wstrb    = r_mem_wstrb;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_arbiter
// Purpose  : Self-checking bench for sram_bus_arbiter: table of directed
//            single transactions, hand-written tie/reset/spurious sequences,
//            and a randomized phase checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.RR_EN(1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: expected held rdata per port, last port served.
    logic [31:0] m_inst_rd;
    logic [31:0] m_data_rd;
    bit          m_last_data;

    typedef struct {
        logic        is_data;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;        // cycles mem_req is left unaccepted
        int          dw;        // cycles from acceptance to response
        logic        exp_wr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        int          exp_lat;   // request cycle to data_ok sample
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction driven and answered per the vector's timing.
    task automatic run_vec(input vec_t v, input string tag);
        int   seen, wcnt, lat, bad_pay;
        bit   accepted, done, right_ok;
        logic [31:0] got_rd;
        seen = 0; wcnt = 0; lat = -1; bad_pay = 0;
        accepted = 0; done = 0; right_ok = 0; got_rd = 'x;
        if (v.is_data) begin
            data_req = 1'b1; data_wen = v.wen; data_addr = v.addr; data_wdata = v.wdata;
        end else begin
            inst_req = 1'b1; inst_addr = v.addr;
        end
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        for (int t = 1; t <= 40 && !done; t++) begin
            tick();
            mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = $urandom;
            if (inst_data_ok || data_data_ok) begin
                done = 1; lat = t;
                right_ok = v.is_data ? (data_data_ok && !inst_data_ok)
                                     : (inst_data_ok && !data_data_ok);
                got_rd = v.is_data ? data_rdata : inst_rdata;
                inst_req = 1'b0; data_req = 1'b0;
            end else if (!accepted && mem_req) begin
                if ({mem_wr, mem_wstrb, mem_addr, mem_wdata} !==
                    {v.exp_wr, v.exp_wstrb, v.addr, v.exp_wdata}) bad_pay++;
                if (seen == v.aw) begin
                    accepted = 1; mem_addr_ok = 1'b1;
                    if (v.dw == 0) begin
                        mem_data_ok = 1'b1; mem_rdata = v.rdata;
                    end else begin
                        wcnt = v.dw;
                    end
                end
                seen++;
            end else if (accepted) begin
                if (mem_req) bad_pay++;
                if (wcnt > 0) begin
                    wcnt--;
                    if (wcnt == 0) begin
                        mem_data_ok = 1'b1; mem_rdata = v.rdata;
                    end
                end
            end
        end
        check({tag, "_latency"}, 72'(lat), 72'(v.exp_lat));
        check({tag, "_payload"}, 72'(bad_pay), 72'd0);
        check({tag, "_okport"}, 72'(right_ok), 72'd1);
        check({tag, "_rdata"}, 72'(got_rd), 72'(v.rdata));
        if (done) begin
            if (v.is_data) m_data_rd = v.rdata; else m_inst_rd = v.rdata;
            m_last_data = v.is_data;
        end
        tick();
        check({tag, "_pulse"}, 72'({inst_data_ok, data_data_ok, busy}), 72'd0);
    endtask

    // mem_data_ok while idle must neither pulse data_ok nor touch rdata.
    task automatic spurious(input string tag);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_data_ok = 1'b0;
        check({tag, "_1"}, 72'({inst_data_ok, data_data_ok, inst_rdata, data_rdata}),
              72'({2'b00, m_inst_rd, m_data_rd}));
        tick();
        check({tag, "_2"}, 72'({inst_data_ok, data_data_ok, inst_rdata, data_rdata}),
              72'({2'b00, m_inst_rd, m_data_rd}));
    endtask

    // Both ports request together; each holds req through its completion
    // cycle. exp_ord: first completion in bit 1 (1 = data).
    task automatic run_tie(input logic [1:0] exp_ord, input string tag);
        logic [1:0] ord;
        int dcnt, icnt;
        bit drop_i, drop_d;
        ord = 2'b00; dcnt = 0; icnt = 0; drop_i = 0; drop_d = 0;
        inst_req = 1'b1; inst_addr = 32'hBFC00010;
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h00001000; data_wdata = 32'h0;
        for (int t = 0; t < 20; t++) begin
            tick();
            mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
            if (drop_i) begin inst_req = 1'b0; drop_i = 0; end
            if (drop_d) begin data_req = 1'b0; drop_d = 0; end
            if (data_data_ok) begin dcnt++; ord = {ord[0], 1'b1}; drop_d = 1; end
            if (inst_data_ok) begin icnt++; ord = {ord[0], 1'b0}; drop_i = 1; end
            if (mem_req) begin
                mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = mem_addr;
            end
        end
        check({tag, "_order"}, 72'(ord), 72'(exp_ord));
        check({tag, "_counts"}, 72'({dcnt[7:0], icnt[7:0]}), 72'({8'd1, 8'd1}));
        m_inst_rd = 32'hBFC00010; m_data_rd = 32'h00001000;
        m_last_data = exp_ord[0];
        check({tag, "_rdata"}, 72'({inst_rdata, data_rdata}), 72'({m_inst_rd, m_data_rd}));
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        m_inst_rd = 32'h0; m_data_rd = 32'h0; m_last_data = 1'b0;
    endtask

    // Randomized-phase state
    bit          i_act, d_act, slv_out, cmp_v, cmp_data, owner_data;
    bit          prev_req, prev_aok, prev_pi, prev_pd, exp_io, exp_do;
    int          i_idle, d_idle, i_age, d_age, slv_dly;
    logic [31:0] cmp_rd;
    logic [68:0] prev_pay, exp_pay;

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        m_inst_rd = 32'h0; m_data_rd = 32'h0; m_last_data = 1'b0;

        vecs[0] = '{is_data:1'b0, wen:4'h0, addr:32'hBFC00000, wdata:32'h0,
                    rdata:32'h3C08BFAF, aw:1, dw:2,
                    exp_wr:1'b0, exp_wstrb:4'h0, exp_wdata:32'h0, exp_lat:5};
        vecs[1] = '{is_data:1'b1, wen:4'h3, addr:32'h00002002, wdata:32'hAABB1234,
                    rdata:32'h0BAD0BAD, aw:0, dw:0,
                    exp_wr:1'b1, exp_wstrb:4'h3, exp_wdata:32'hAABB1234, exp_lat:2};
        vecs[2] = '{is_data:1'b1, wen:4'h0, addr:32'h00001000, wdata:32'h55555555,
                    rdata:32'h12345678, aw:0, dw:1,
                    exp_wr:1'b0, exp_wstrb:4'h0, exp_wdata:32'h55555555, exp_lat:3};
        vecs[3] = '{is_data:1'b1, wen:4'hF, addr:32'h00000040, wdata:32'hCAFEF00D,
                    rdata:32'h00000000, aw:5, dw:0,
                    exp_wr:1'b1, exp_wstrb:4'hF, exp_wdata:32'hCAFEF00D, exp_lat:7};

        // Reset state
        tick(); tick();
        check("reset_outputs", 72'(|{mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
              inst_rdata, data_rdata, inst_data_ok, data_data_ok, busy}), 72'd0);
        resetn = 1'b1;
        tick();
        check("post_reset_idle", 72'({mem_req, busy, inst_data_ok, data_data_ok}), 72'd0);

        spurious("spurious_fresh");
        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        spurious("spurious_held");

        // Tie: data wins after an inst completion, inst wins after a data one.
        run_vec(vecs[0], "pre_tie1");
        run_tie(2'b10, "tie1");
        run_vec(vecs[2], "pre_tie2");
        run_tie(2'b01, "tie2");

        // Reset while a read sits in the data-wait phase.
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h00003000;
        for (int t = 0; t < 10 && !mem_req; t++) tick();
        check("rstmid_req", 72'(mem_req), 72'd1);
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("rstmid_zero", 72'(|{mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
              inst_rdata, data_rdata, inst_data_ok, data_data_ok, busy}), 72'd0);
        tick();
        resetn = 1'b1; data_req = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF;
        m_inst_rd = 32'h0; m_data_rd = 32'h0; m_last_data = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            mem_data_ok = 1'b0;
            check("rstmid_no_ok", 72'({inst_data_ok, data_data_ok, busy, inst_rdata, data_rdata}),
                  72'd0);
        end
        run_vec(vecs[2], "rstmid_next");

        // Randomized traffic against a transaction-level model.
        reset_pulse();
        i_act = 0; d_act = 0; i_idle = 0; d_idle = 0; i_age = 0; d_age = 0;
        slv_out = 0; slv_dly = 0; cmp_v = 0; cmp_data = 0; cmp_rd = 32'h0;
        owner_data = 0; prev_req = 0; prev_aok = 0; prev_pi = 0; prev_pd = 0;
        prev_pay = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            // Responses: exactly the port that owned the completed transaction
            // pulses, with the word the slave returned; rdata otherwise holds.
            exp_io = cmp_v && !cmp_data;
            exp_do = cmp_v && cmp_data;
            if (exp_io) m_inst_rd = cmp_rd;
            if (exp_do) m_data_rd = cmp_rd;
            if (cmp_v) m_last_data = cmp_data;
            check("rnd_resp", 72'({inst_data_ok, data_data_ok, inst_rdata, data_rdata}),
                  72'({exp_io, exp_do, m_inst_rd, m_data_rd}));
            cmp_v = 0;

            // Bus request behaviour.
            if (prev_req && !prev_aok) begin
                check("rnd_hold", 72'({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}),
                      72'({1'b1, prev_pay}));
            end else if (prev_req && prev_aok) begin
                check("rnd_drop", 72'(mem_req), 72'd0);
            end else if (mem_req) begin
                check("rnd_grant_pend", 72'(prev_pi || prev_pd), 72'd1);
                if (prev_pi && prev_pd) owner_data = m_last_data ? 1'b0 : 1'b1;
                else                    owner_data = prev_pd;
                if (owner_data) exp_pay = {|data_wen, data_wen, data_addr, data_wdata};
                else            exp_pay = {1'b0, 4'h0, inst_addr, 32'h0};
                check("rnd_grant", 72'({mem_wr, mem_wstrb, mem_addr, mem_wdata}), 72'(exp_pay));
            end

            // Masters
            if (inst_data_ok && i_act) begin i_act = 0; i_idle = $urandom_range(0, 2); end
            if (data_data_ok && d_act) begin d_act = 0; d_idle = $urandom_range(0, 2); end
            if (!i_act) begin
                if (i_idle > 0) begin
                    i_idle--; inst_req = 1'b0;
                end else begin
                    i_act = 1; i_age = 0; inst_req = 1'b1;
                    inst_addr = $urandom & 32'hFFFF_FFFC;
                end
            end else begin
                i_age++;
                if (i_age == 300) check("rnd_inst_timeout", 72'(i_age), 72'd0);
            end
            if (!d_act) begin
                if (d_idle > 0) begin
                    d_idle--; data_req = 1'b0;
                end else begin
                    d_act = 1; d_age = 0; data_req = 1'b1;
                    data_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                    data_addr = $urandom; data_wdata = $urandom;
                end
            end else begin
                d_age++;
                if (d_age == 300) check("rnd_data_timeout", 72'(d_age), 72'd0);
            end
            prev_pi = inst_req && !inst_data_ok;
            prev_pd = data_req && !data_data_ok;

            // Slave
            mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = $urandom;
            if (mem_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    mem_addr_ok = 1'b1;
                    if ($urandom_range(0, 3) == 0) begin
                        mem_data_ok = 1'b1;
                        cmp_v = 1; cmp_data = owner_data; cmp_rd = mem_rdata;
                    end else begin
                        slv_out = 1; slv_dly = $urandom_range(0, 3);
                    end
                end
            end else if (slv_out) begin
                if (slv_dly == 0) begin
                    mem_data_ok = 1'b1; slv_out = 0;
                    cmp_v = 1; cmp_data = owner_data; cmp_rd = mem_rdata;
                end else begin
                    slv_dly--;
                end
                if ($urandom_range(0, 3) == 0) mem_addr_ok = 1'b1;
            end else begin
                if ($urandom_range(0, 7) == 0) mem_data_ok = 1'b1;
                if ($urandom_range(0, 7) == 0) mem_addr_ok = 1'b1;
            end
            prev_req = mem_req;
            prev_aok = mem_addr_ok;
            prev_pay = {mem_wr, mem_wstrb, mem_addr, mem_wdata};
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // One completion pulse at a time, whatever the phase.
    always @(negedge clk) begin
        if (inst_data_ok && data_data_ok) begin
            errors++;
            $display("FAIL both_ok: got inst_data_ok=1 data_data_ok=1 expected at most one");
        end
    end

endmodule
`default_nettype wire
